simon_9696: RTL and testbench
=============================

# simon_9696

Iterative SIMON 96/96 block cipher core (48-bit words, 2-word key, 52 rounds) with key-load and data-load request/acknowledge handshakes. The host supplies a 96-bit key and 96-bit blocks. The core expands and stores all round keys, then encrypts or decrypts one block at a time at one round per clock. It sits between a host-side loader and result reader, which control it only through the level handshakes below.

## Interface
Parameters:
- N, 48, word width in bits
- M, 2, key words
- T, 52, rounds
- Co, 6, round-counter width (2^Co ≥ T)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- nR  in  1  reset, asynchronous, active-low
- newData  in  1  host has a block on inData (level)
- newKey  in  1  host has a key on key (level)
- enc_dec  in  1  1 = encrypt, 0 = decrypt; sampled at data load
- readData  in  1  host has taken outData (level)
- inData  in  [1:0][N-1:0]  block; [1] = x (upper word), [0] = y
- key  in  [M-1:0][N-1:0]  key; [1] = k1, [0] = k0
- loadData  out  1  one-cycle pulse: block captured
- loadKey  out  1  one-cycle pulse: key captured
- doneData  out  1  result valid on outData
- doneKey  out  1  round-key store valid
- outData  out  [1:0][N-1:0]  result, same word order as inData
- mode  out  4  status: [0] key expansion busy, [1] keys valid, [2] rounds busy, [3] result pending

## Operation
- Round function: f(x) = (x<<<1 & x<<<8) ^ (x<<<2).
- Encrypt round i: (x, y) ← (y ^ f(x) ^ rk[i], x), for i = 0..T-1.
- Decrypt round: (x, y) ← (y, x ^ f(y) ^ rk[i]), for i = T-1..0.
- Key schedule:
  - rk[0] = k0, rk[1] = k1.
  - rk[i+2] = c ^ z ^ rk[i] ^ (r ^ (r>>>1)), where r = rk[i+1]>>>3.
  - c = 2^N-4 (0xFFFFFFFFFFFC).
  - z = bit i mod 62 of z2 = 10101111011100000011010010011000101000010001111110010110110011; bit 0 is leftmost; the bit enters at the LSB.
- Round keys are held in a T×N register file, written during expansion and read in forward order for encrypt, reverse order for decrypt.
- Key states: KIDLE → KEXP → KREADY.
  - Key load: newKey high, no key expansion running, rounds not busy → loadKey pulse, k0/k1 captured, doneKey cleared, enter KEXP.
  - Expansion: one round key per cycle for T-M cycles, then doneKey = 1 (KREADY).
  - newKey is level-sensitive: if it is still high on re-entry to KREADY, a new expansion starts.
- Data states: DIDLE → DRUN → DDONE.
  - Data load: newData high, doneKey = 1, state DIDLE → loadData pulse; inData and enc_dec captured.
  - DRUN runs T rounds at one round per cycle.
  - DDONE: outData registered, doneData = 1.
  - doneData stays high until readData is sampled high, then the core returns to DIDLE. outData holds its value until the next result.
- newData arriving while in DDONE waits; the next block loads in the cycle after doneData falls.
- newData and newKey asserted together: the key loads first, and data loads once doneKey = 1.

## Timing
- Reset (nR low, any time, including mid-operation): all outputs 0, mode = 0, both FSMs return to idle, key store invalid, round counter 0. Any operation in progress is aborted with no result.
- Key latency: loadKey at edge E; doneKey rises at E + (T-M) = E + 50 cycles.
- Data latency: loadData at edge E; doneData and outData valid at E + T = E + 52 cycles.
- The host must drop newData / newKey within 50 cycles of the corresponding load pulse, or the load repeats.
- readData high while doneData = 0 is ignored.
- Back-to-back blocks: next loadData no earlier than 1 cycle after doneData falls.

## Test plan
- Encrypt: key1 = 0D0C0B0A0908, key0 = 050403020100, plaintext 2072616C6C69_702065687420 → loadKey pulse, doneKey after 50 cycles; outData = 602807A462B4_69063D8FF082 52 cycles after loadData.
- Decrypt: same key, enc_dec = 0, inData = 602807A462B4_69063D8FF082 → outData = 2072616C6C69_702065687420.
- Stream of 5 blocks (2072616C6C69702065687420, A8D5F7DE0123FEDC01234567, 5BC92D014567BA9889ABCDEF, F2B48D4589AB765401234567, 567F11DECDEF321089ABCDEF), with newData raised while doneData is high → each load waits for readData; then reset, decrypt all 5 ciphertexts → original plaintexts recovered.
- Handshake: hold readData low for 100 cycles → doneData stays 1 and outData stable; raise readData → doneData falls next edge.
- Reset mid-rounds (nR low 20 cycles after loadData) → all outputs 0 immediately; after release no doneData until a new key and block are loaded.
- newData without key → no loadData until doneKey = 1.

Source files
------------

// File: rtl/simon_9696.sv
// Iterative SIMON 96/96 core: expands the key into a round-key file, then runs
// one round per clock in either direction under level request/acknowledge handshakes.
module simon_9696 #(
    parameter int N  = 48,
    parameter int M  = 2,
    parameter int T  = 52,
    parameter int Co = 6
) (
    input  logic                clk,
    input  logic                nR,
    input  logic                newData,
    input  logic                newKey,
    input  logic                enc_dec,
    input  logic                readData,
    input  logic [1:0][N-1:0]   inData,
    input  logic [M-1:0][N-1:0] key,
    output logic                loadData,
    output logic                loadKey,
    output logic                doneData,
    output logic                doneKey,
    output logic [1:0][N-1:0]   outData,
    output logic [3:0]          mode
);

    typedef enum logic [1:0] {KIDLE, KEXP, KREADY} kState_t;
    typedef enum logic [1:0] {DIDLE, DRUN, DDONE} dState_t;

    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [N-1:0] C = {{(N-2){1'b1}}, 2'b00};

    function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int unsigned s);
        return (v << s) | (v >> (N - s));
    endfunction

    function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int unsigned s);
        return (v >> s) | (v << (N - s));
    endfunction

    function automatic logic [N-1:0] f(input logic [N-1:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    kState_t kState, kNext;
    dState_t dState, dNext;

    logic [N-1:0]  rkFile [T];
    logic [Co-1:0] kCnt, rCnt;
    logic [Co-1:0] kIdx1, kIdx2, rIdx;
    logic [N-1:0]  xReg, yReg, xNext, yNext;
    logic [N-1:0]  rkSrc0, rkSrc1, rot3, newRk, roundKey;
    logic [61:0]   zWord;
    logic          zBit;
    logic          encMode;
    logic          keyGo, dataGo;

    // Key load wins over data load when both are requested in the same cycle.
    assign keyGo  = newKey && (kState != KEXP) && (dState != DRUN);
    assign dataGo = newData && doneKey && (dState == DIDLE) && !keyGo;

    assign mode = {dState == DDONE, dState == DRUN, doneKey, kState == KEXP};

    always_comb begin
        kIdx1    = kCnt + Co'(1);
        kIdx2    = kCnt + Co'(2);
        rkSrc0   = rkFile[kCnt];
        rkSrc1   = rkFile[kIdx1];
        zWord    = Z2 << kCnt;
        zBit     = zWord[61];
        rot3     = ror(rkSrc1, 3);
        newRk    = C ^ {{(N-1){1'b0}}, zBit} ^ rkSrc0 ^ rot3 ^ ror(rot3, 1);
        rIdx     = encMode ? rCnt : (Co'(T - 1) - rCnt);
        roundKey = rkFile[rIdx];
        if (encMode) begin
            xNext = yReg ^ f(xReg) ^ roundKey;
            yNext = xReg;
        end else begin
            xNext = yReg;
            yNext = xReg ^ f(yReg) ^ roundKey;
        end
    end

    always_comb begin
        kNext = kState;
        unique case (kState)
            KIDLE, KREADY: if (keyGo) kNext = KEXP;
            KEXP:          if (kCnt == Co'(T - M - 1)) kNext = KREADY;
            default:       kNext = KIDLE;
        endcase
    end

    always_comb begin
        dNext = dState;
        unique case (dState)
            DIDLE:   if (dataGo) dNext = DRUN;
            DRUN:    if (rCnt == Co'(T - 1)) dNext = DDONE;
            DDONE:   if (readData) dNext = DIDLE;
            default: dNext = DIDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (keyGo) begin
            rkFile[0] <= key[0];
            rkFile[1] <= key[1];
        end else if (kState == KEXP) begin
            rkFile[kIdx2] <= newRk;
        end
    end

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            kState   <= KIDLE;
            dState   <= DIDLE;
            kCnt     <= '0;
            rCnt     <= '0;
            loadKey  <= 1'b0;
            loadData <= 1'b0;
            doneKey  <= 1'b0;
            doneData <= 1'b0;
            xReg     <= '0;
            yReg     <= '0;
            encMode  <= 1'b0;
            outData  <= '0;
        end else begin
            kState   <= kNext;
            dState   <= dNext;
            loadKey  <= keyGo;
            loadData <= dataGo;

            if (keyGo) begin
                kCnt    <= '0;
                doneKey <= 1'b0;
            end else if (kState == KEXP) begin
                kCnt <= kIdx1;
                if (kCnt == Co'(T - M - 1)) doneKey <= 1'b1;
            end

            if (dataGo) begin
                xReg    <= inData[1];
                yReg    <= inData[0];
                encMode <= enc_dec;
                rCnt    <= '0;
            end else if (dState == DRUN) begin
                xReg <= xNext;
                yReg <= yNext;
                rCnt <= rCnt + Co'(1);
                if (rCnt == Co'(T - 1)) begin
                    outData  <= {xNext, yNext};
                    doneData <= 1'b1;
                    rCnt     <= '0;
                end
            end else if (dState == DDONE && readData) begin
                doneData <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_simon_9696.sv
// Self-checking bench for simon_9696: vector table plus handshake, streaming
// and reset sequences, all checked against a word-level SIMON 96/96 model.
module tb_simon_9696;

    logic              clk = 1'b0;
    logic              nR;
    logic              newData, newKey, enc_dec, readData;
    logic [1:0][47:0]  inData;
    logic [1:0][47:0]  key;
    logic              loadData, loadKey, doneData, doneKey;
    logic [1:0][47:0]  outData;
    logic [3:0]        mode;

    simon_9696 #(.N(48), .M(2), .T(52), .Co(6)) dut (
        .clk(clk), .nR(nR), .newData(newData), .newKey(newKey), .enc_dec(enc_dec),
        .readData(readData), .inData(inData), .key(key), .loadData(loadData),
        .loadKey(loadKey), .doneData(doneData), .doneKey(doneKey),
        .outData(outData), .mode(mode)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    string       z2s = "10101111011100000011010010011000101000010001111110010110110011";
    logic [47:0] mrk [52];

    function automatic logic [47:0] mrol(input logic [47:0] v, input int s);
        return (v << s) | (v >> (48 - s));
    endfunction

    function automatic logic [47:0] mror(input logic [47:0] v, input int s);
        return (v >> s) | (v << (48 - s));
    endfunction

    function automatic logic [47:0] mf(input logic [47:0] v);
        return (mrol(v, 1) & mrol(v, 8)) ^ mrol(v, 2);
    endfunction

    task automatic modelKey(input logic [47:0] k1, input logic [47:0] k0);
        logic [47:0] r;
        logic [47:0] z;
        mrk[0] = k0;
        mrk[1] = k1;
        for (int i = 0; i < 50; i++) begin
            r = mror(mrk[i+1], 3);
            z = (z2s[i % 62] == 8'h31) ? 48'd1 : 48'd0;
            mrk[i+2] = 48'hFFFFFFFFFFFC ^ z ^ mrk[i] ^ r ^ mror(r, 1);
        end
    endtask

    task automatic modelCrypt(input logic [47:0] xi, input logic [47:0] yi, input logic enc,
                              output logic [47:0] xo, output logic [47:0] yo);
        logic [47:0] x, y, t;
        x = xi;
        y = yi;
        for (int j = 0; j < 52; j++) begin
            if (enc) begin
                t = x;
                x = y ^ mf(x) ^ mrk[j];
                y = t;
            end else begin
                t = y;
                y = x ^ mf(y) ^ mrk[51 - j];
                x = t;
            end
        end
        xo = x;
        yo = y;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return loadKey;
            1:       return doneKey;
            2:       return loadData;
            default: return doneData;
        endcase
    endfunction

    task automatic waitSig(input int sel, input int maxc, input string name, output int lat);
        lat = 0;
        for (int i = 0; i < maxc; i++) begin
            tick();
            lat++;
            if (sig(sel)) return;
        end
        checks++;
        errors++;
        $display("FAIL %s timeout after %0d cycles", name, maxc);
        lat = -1;
    endtask

    logic [47:0] curK1, curK0;

    task automatic loadKeyTask(input logic [47:0] k1, input logic [47:0] k0, input string name);
        int lat;
        key[1] = k1;
        key[0] = k0;
        newKey = 1'b1;
        waitSig(0, 300, {name, "_loadKey"}, lat);
        newKey = 1'b0;
        tick();
        chk({name, "_loadKeyPulse"}, 96'(loadKey), 96'd0);
        chk({name, "_modeExp"}, 96'(mode[1:0]), 96'(2'b01));
        waitSig(1, 100, {name, "_doneKey"}, lat);
        chk({name, "_keyLatency"}, 96'(lat + 1), 96'd50);
        chk({name, "_modeReady"}, 96'(mode[1:0]), 96'(2'b10));
        modelKey(k1, k0);
        curK1 = k1;
        curK0 = k0;
    endtask

    task automatic runBlock(input logic [47:0] x, input logic [47:0] y, input logic enc,
                            input logic [47:0] ex, input logic [47:0] ey, input string name);
        int lat;
        inData[1] = x;
        inData[0] = y;
        enc_dec = enc;
        newData = 1'b1;
        waitSig(2, 300, {name, "_load"}, lat);
        newData = 1'b0;
        chk({name, "_modeRun"}, 96'(mode[3:2]), 96'(2'b01));
        waitSig(3, 200, {name, "_done"}, lat);
        chk({name, "_latency"}, 96'(lat), 96'd52);
        chk({name, "_out"}, outData, {ex, ey});
        readData = 1'b1;
        tick();
        readData = 1'b0;
        chk({name, "_doneFall"}, 96'({doneData, mode[3:2]}), 96'd0);
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic [47:0] k1, k0, x, y, ex, ey;
        logic        enc;
        string       name;
    } vec_t;

    vec_t        tbl [8];
    logic [47:0] ptX [5], ptY [5], ctX [5], ctY [5];
    logic [47:0] rk1, rk0, ex, ey, rx, ry;
    logic        keyLoaded;
    logic        stable;
    int          seen, lat;

    initial begin
        nR = 1'b0; newData = 1'b0; newKey = 1'b0; enc_dec = 1'b0; readData = 1'b0;
        inData = '0; key = '0;
        curK1 = '0; curK0 = '0; keyLoaded = 1'b0;

        tbl[0] = '{48'h0D0C0B0A0908, 48'h050403020100, 48'h2072616C6C69, 48'h702065687420,
                   48'h602807A462B4, 48'h69063D8FF082, 1'b1, "kat_enc"};
        tbl[1] = '{48'h0D0C0B0A0908, 48'h050403020100, 48'h602807A462B4, 48'h69063D8FF082,
                   48'h2072616C6C69, 48'h702065687420, 1'b0, "kat_dec"};
        for (int i = 2; i < 8; i++) begin
            if (i == 2 || i == 5) begin
                rk1 = 48'({$urandom(), $urandom()});
                rk0 = 48'({$urandom(), $urandom()});
            end
            tbl[i].k1 = rk1;
            tbl[i].k0 = rk0;
            tbl[i].x = 48'({$urandom(), $urandom()});
            tbl[i].y = 48'({$urandom(), $urandom()});
            tbl[i].enc = 1'($urandom_range(0, 1));
            tbl[i].name = $sformatf("rand%0d", i);
            modelKey(rk1, rk0);
            modelCrypt(tbl[i].x, tbl[i].y, tbl[i].enc, ex, ey);
            tbl[i].ex = ex;
            tbl[i].ey = ey;
        end

        repeat (3) tick();
        chk("reset_out", outData, 96'd0);
        chk("reset_flags", 96'({loadData, loadKey, doneData, doneKey, mode}), 96'd0);
        nR = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            if (!keyLoaded || tbl[i].k1 != curK1 || tbl[i].k0 != curK0) begin
                loadKeyTask(tbl[i].k1, tbl[i].k0, tbl[i].name);
                keyLoaded = 1'b1;
            end
            runBlock(tbl[i].x, tbl[i].y, tbl[i].enc, tbl[i].ex, tbl[i].ey, tbl[i].name);
        end

        // Result holds under a slow reader; readData during rounds is ignored.
        rx = 48'({$urandom(), $urandom()});
        ry = 48'({$urandom(), $urandom()});
        modelCrypt(rx, ry, 1'b1, ex, ey);
        inData[1] = rx; inData[0] = ry; enc_dec = 1'b1; newData = 1'b1;
        waitSig(2, 300, "hs_load", lat);
        newData = 1'b0;
        repeat (5) tick();
        readData = 1'b1;
        repeat (5) tick();
        readData = 1'b0;
        waitSig(3, 200, "hs_done", lat);
        chk("hs_latency", 96'(lat + 10), 96'd52);
        chk("hs_out", outData, {ex, ey});
        stable = 1'b1;
        repeat (100) begin
            tick();
            if (doneData !== 1'b1 || outData !== {ex, ey}) stable = 1'b0;
        end
        chk("hs_hold", 96'(stable), 96'd1);
        readData = 1'b1;
        tick();
        readData = 1'b0;
        chk("hs_doneFall", 96'(doneData), 96'd0);
        chk("hs_outHeld", outData, {ex, ey});

        // Streaming: next block requested while the previous result is pending.
        ptX[0] = 48'h2072616C6C69; ptY[0] = 48'h702065687420;
        ptX[1] = 48'hA8D5F7DE0123; ptY[1] = 48'hFEDC01234567;
        ptX[2] = 48'h5BC92D014567; ptY[2] = 48'hBA9889ABCDEF;
        ptX[3] = 48'hF2B48D4589AB; ptY[3] = 48'h765401234567;
        ptX[4] = 48'h567F11DECDEF; ptY[4] = 48'h321089ABCDEF;
        loadKeyTask(48'h0D0C0B0A0908, 48'h050403020100, "strkey");
        for (int b = 0; b < 5; b++) modelCrypt(ptX[b], ptY[b], 1'b1, ctX[b], ctY[b]);
        chk("str_kat_model", {ctX[0], ctY[0]}, {48'h602807A462B4, 48'h69063D8FF082});

        inData[1] = ptX[0]; inData[0] = ptY[0]; enc_dec = 1'b1; newData = 1'b1;
        waitSig(2, 300, "str_load0", lat);
        newData = 1'b0;
        for (int b = 0; b < 5; b++) begin
            waitSig(3, 200, "str_done", lat);
            chk($sformatf("str%0d_latency", b), 96'(lat), 96'd52);
            chk($sformatf("str%0d_out", b), outData, {ctX[b], ctY[b]});
            if (b < 4) begin
                inData[1] = ptX[b+1]; inData[0] = ptY[b+1]; newData = 1'b1;
                seen = 0;
                repeat (5) begin
                    tick();
                    if (loadData) seen++;
                end
                chk($sformatf("str%0d_waitLoad", b), 96'(seen), 96'd0);
                chk($sformatf("str%0d_stillDone", b), 96'(doneData), 96'd1);
                readData = 1'b1;
                tick();
                readData = 1'b0;
                chk($sformatf("str%0d_doneFall", b), 96'(doneData), 96'd0);
                tick();
                chk($sformatf("str%0d_nextLoad", b), 96'(loadData), 96'd1);
                newData = 1'b0;
            end else begin
                readData = 1'b1;
                tick();
                readData = 1'b0;
            end
        end

        nR = 1'b0;
        repeat (3) tick();
        nR = 1'b1;
        tick();
        loadKeyTask(48'h0D0C0B0A0908, 48'h050403020100, "deckey");
        for (int b = 0; b < 5; b++)
            runBlock(ctX[b], ctY[b], 1'b0, ptX[b], ptY[b], $sformatf("dec%0d", b));

        // Asynchronous reset in the middle of the rounds.
        inData[1] = ptX[1]; inData[0] = ptY[1]; enc_dec = 1'b1; newData = 1'b1;
        waitSig(2, 300, "mid_load", lat);
        newData = 1'b0;
        repeat (20) tick();
        #2 nR = 1'b0;
        #1;
        chk("mid_rst_out", outData, 96'd0);
        chk("mid_rst_flags", 96'({loadData, loadKey, doneData, doneKey, mode}), 96'd0);
        repeat (2) tick();
        nR = 1'b1;

        // Block requested with no valid key: must wait for a key load.
        inData[1] = ptX[0]; inData[0] = ptY[0]; enc_dec = 1'b1; newData = 1'b1;
        seen = 0;
        repeat (80) begin
            tick();
            if (loadData || doneData) seen++;
        end
        chk("nokey_noLoad", 96'(seen), 96'd0);
        loadKeyTask(48'h0D0C0B0A0908, 48'h050403020100, "nokey");
        waitSig(2, 5, "nokey_load", lat);
        chk("nokey_loadAfterKey", 96'(lat), 96'd1);
        newData = 1'b0;
        waitSig(3, 200, "nokey_done", lat);
        chk("nokey_latency", 96'(lat), 96'd52);
        chk("nokey_out", outData, {48'h602807A462B4, 48'h69063D8FF082});
        readData = 1'b1;
        tick();
        readData = 1'b0;
        chk("nokey_doneFall", 96'(doneData), 96'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
